// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multi-cycle shifter, amount = ~i_arg_B, STEP bits per cycle
// Optional rotate-right (mode 11) enabled by defining SHIFT_ROTATE_EN.
module shift_unit_seq #(
    parameter int BITS = 32,
    parameter int STEP = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    input  logic [1:0]      i_mode,
    output logic [BITS-1:0] o_result,
    output logic            o_valid,
    output logic            o_busy,
    output logic            o_error,
    output logic            o_overflow
);

    localparam int RW = $clog2(BITS + 1);
    localparam logic [BITS-1:0] BITS_V = BITS'(BITS);
    localparam logic [RW-1:0]   BITS_R = RW'(BITS);
    localparam logic [RW-1:0]   STEP_R = RW'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [BITS-1:0] work;
    logic [RW-1:0]   rem;
    logic [1:0]      mode_q;

    logic [BITS-1:0] amt;
    logic            amt_neg;
    logic            mode_bad;
    logic [RW-1:0]   s;
    logic [RW-1:0]   rem_nx;
    logic [BITS-1:0] work_nx;
    logic [BITS-1:0] full_shift;

    // The amount is the one's complement of B, interpreted as signed.
    assign amt     = ~i_arg_B;
    assign amt_neg = amt[BITS-1];

`ifdef SHIFT_ROTATE_EN
    assign mode_bad = 1'b0;
`else
    assign mode_bad = (i_mode == 2'b11);
`endif

    assign s      = (rem > STEP_R) ? STEP_R : rem;
    assign rem_nx = rem - s;

    always_comb begin
        work_nx = work;
        case (mode_q)
            2'b00:   work_nx = work >> s;
            // MSB of work still holds the captured sign, so >>> fills correctly
            2'b01:   work_nx = $unsigned($signed(work) >>> s);
            2'b10:   work_nx = work << s;
            default: begin
`ifdef SHIFT_ROTATE_EN
                work_nx = (work >> s) | (work << (BITS_R - s));
`else
                work_nx = work;
`endif
            end
        endcase
    end

    always_comb begin
        full_shift = '0;
        case (i_mode)
            2'b01:   full_shift = {BITS{i_arg_A[BITS-1]}};
            2'b11:   full_shift = i_arg_A;
            default: full_shift = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            work       <= '0;
            rem        <= '0;
            mode_q     <= '0;
            o_result   <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_error    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        mode_q     <= i_mode;
                        o_error    <= 1'b0;
                        o_overflow <= 1'b0;
                        o_busy     <= 1'b1;
                        if (mode_bad || amt_neg) begin
                            o_error  <= 1'b1;
                            o_result <= '0;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else if (amt > BITS_V) begin
                            o_overflow <= 1'b1;
                            o_result   <= '0;
                            o_valid    <= 1'b1;
                            state      <= DONE;
                        end else if (amt == '0) begin
                            o_result <= i_arg_A;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else if (amt == BITS_V) begin
                            o_result <= full_shift;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            work  <= i_arg_A;
                            rem   <= amt[RW-1:0];
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_nx;
                    rem  <= rem_nx;
                    if (rem_nx == '0) begin
                        o_result <= work_nx;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - randomized self-checking bench for shift_unit_seq
module tb_shift_unit_seq;

    localparam int BITS = 32;
    localparam int STEP = 4;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_start = 1'b0;
    logic [BITS-1:0] i_arg_A = '0;
    logic [BITS-1:0] i_arg_B = '0;
    logic [1:0]      i_mode = '0;
    logic [BITS-1:0] o_result;
    logic            o_valid;
    logic            o_busy;
    logic            o_error;
    logic            o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    shift_unit_seq #(.BITS(BITS), .STEP(STEP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_arg_A(i_arg_A), .i_arg_B(i_arg_B), .i_mode(i_mode),
        .o_result(o_result), .o_valid(o_valid), .o_busy(o_busy),
        .o_error(o_error), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: result straight from shift operators, latency from the cycle-count rule.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                  output logic [31:0] r, output logic e, output logic ov,
                                  output int lat);
        int amt;
        logic [63:0] dbl;
        logic rot_en;
`ifdef SHIFT_ROTATE_EN
        rot_en = 1'b1;
`else
        rot_en = 1'b0;
`endif
        amt = $signed(~b);
        r = '0; e = 1'b0; ov = 1'b0; lat = 1;
        if ((m == 2'b11 && !rot_en) || amt < 0) e = 1'b1;
        else if (amt > BITS) ov = 1'b1;
        else begin
            case (m)
                2'b00: r = a >> amt;
                2'b01: r = $signed(a) >>> amt;
                2'b10: r = a << amt;
                default: begin
                    dbl = {a, a} >> amt;
                    r = dbl[31:0];
                end
            endcase
            if (amt != 0 && amt != BITS) lat = 1 + (amt + STEP - 1) / STEP;
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m);
        logic [31:0] er;
        logic ee, eov;
        int elat, cycles;
        model(a, b, m, er, ee, eov, elat);
        @(negedge i_clk);
        i_arg_A = a; i_arg_B = b; i_mode = m; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        cycles = 1;
        while (!o_valid && cycles < 40) begin
            check({tag, " busy"}, {31'd0, o_busy}, 32'd1);
            @(posedge i_clk); #1;
            cycles++;
        end
        check({tag, " latency"}, cycles, elat);
        check({tag, " result"}, o_result, er);
        check({tag, " error"}, {31'd0, o_error}, {31'd0, ee});
        check({tag, " overflow"}, {31'd0, o_overflow}, {31'd0, eov});
        @(posedge i_clk); #1;
        check({tag, " valid pulse"}, {31'd0, o_valid}, 32'd0);
        check({tag, " idle"}, {31'd0, o_busy}, 32'd0);
        check({tag, " held"}, o_result, er);
    endtask

    initial begin
        int busy_cnt, cycles, amt;
        logic [31:0] a, b;
        logic [1:0] m;

        #1;
        check("reset result", o_result, 32'd0);
        check("reset flags", {28'd0, o_valid, o_busy, o_error, o_overflow}, 32'd0);
        @(negedge i_clk); i_rst = 1'b0;

        run_op("asr5", 32'hF000_0000, 32'hFFFF_FFFA, 2'b01);
        run_op("lsr5", 32'hF000_0000, 32'hFFFF_FFFA, 2'b00);
        run_op("asr32", 32'h8000_0001, 32'hFFFF_FFDF, 2'b01);
        run_op("lsr32", 32'h8000_0001, 32'hFFFF_FFDF, 2'b00);
        run_op("amt0", 32'h8000_0001, 32'hFFFF_FFFF, 2'b10);
        run_op("neg", 32'h1234_5678, 32'h0000_0000, 2'b00);
        run_op("ovf40", 32'h1234_5678, 32'hFFFF_FFD7, 2'b10);
        run_op("rot4", 32'h0000_0001, 32'hFFFF_FFFB, 2'b11);
        run_op("rot32", 32'hCAFE_0001, 32'hFFFF_FFDF, 2'b11);

        // Long left shift with an ignored start pulse mid-flight
        @(negedge i_clk);
        i_arg_A = 32'h1; i_arg_B = 32'hFFFF_FFE0; i_mode = 2'b10; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        cycles = 1;
        busy_cnt = o_busy ? 1 : 0;
        while (!o_valid && cycles < 40) begin
            if (cycles == 3) begin
                @(negedge i_clk);
                i_arg_A = 32'hFFFF_FFFF; i_arg_B = 32'hFFFF_FFFF; i_mode = 2'b00; i_start = 1'b1;
            end
            @(posedge i_clk); #1;
            i_start = 1'b0;
            cycles++;
            if (o_busy) busy_cnt++;
        end
        check("lsl31 latency", cycles, 9);
        check("lsl31 busy count", busy_cnt, 9);
        check("lsl31 result", o_result, 32'h8000_0000);
        @(posedge i_clk); #1;
        check("lsl31 no extra op", {30'd0, o_busy, o_valid}, 32'd0);

        // Abort by reset mid-operation
        run_op("pre-abort", 32'h0000_DEAD, 32'hFFFF_FFFF, 2'b00);
        @(negedge i_clk);
        i_arg_A = 32'hFFFF_FFFF; i_arg_B = ~32'd31; i_mode = 2'b00; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); @(posedge i_clk); #2;
        i_rst = 1'b1;
        #1;
        check("abort result", o_result, 32'd0);
        check("abort flags", {28'd0, o_valid, o_busy, o_error, o_overflow}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk); #1;
            check("abort no valid", {31'd0, o_valid}, 32'd0);
        end
        @(negedge i_clk); i_rst = 1'b0;
        run_op("post-abort amt4", 32'h0000_00F0, ~32'd4, 2'b00);

        // Randomized operations, including back-to-back starts
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       amt = -int'($urandom_range(1, 1000));
                1:       amt = int'($urandom_range(33, 5000));
                2:       amt = (($urandom_range(0, 1) == 1) ? BITS : 0);
                default: amt = int'($urandom_range(1, BITS - 1));
            endcase
            b = ~amt;
            run_op("rand", a, b, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
